vga_pixel_fetch_ctrl: RTL

- Scheduler between a pixel memory and the VGA sync generator.
- Prefetches one pixel word per request, in raster order, into a small FIFO.
- Pops one pixel per active-display clock and drives registered rgb aligned to the generator's registered hsync/vsync.
- Resynchronises at every frame. Detects and recovers from memory underflow without losing raster alignment.

---
 rtl/vga_pixel_fetch_ctrl_if.sv | 18 +
 rtl/vga_pixel_fetch_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch_ctrl_if.sv
// Pixel memory read bus between the fetch controller and the pixel store.
//   mem_req   : read request (controller -> memory), held until mem_ack
//   mem_addr  : word address, stable while mem_req is high
//   mem_ack   : request accepted; mem_rdata is valid in the same cycle
//   mem_rdata : read data (memory -> controller)
// Modports: master = fetch controller, slave = memory.
interface vga_pixel_fetch_ctrl_if #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 12
) ();
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [PIX_W-1:0]  mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/vga_pixel_fetch_ctrl.sv
// Pixel fetch scheduler between a pixel memory and a VGA sync generator.
// Prefetches pixel words in raster order into a small FIFO and pops one
// word per active-display clock, producing registered rgb one clock after
// hpos/vpos (aligned with the generator's registered syncs).  The FIFO and
// fetch address are resynchronised on the first blanking line of every
// frame.  When the FIFO runs dry the slot shows UNDERFLOW_COLOR and a debt
// is recorded so the matching late word is dropped, keeping later pixels
// on their correct raster position.
// Ports:
//   clk        : pixel clock
//   reset      : asynchronous, active-low reset
//   hpos/vpos  : raster position from the sync generator
//   display_on : active-area flag from the sync generator
//   mem        : pixel memory read bus (master side)
//   rgb        : registered pixel output
//   underflow  : sticky underflow flag, cleared only by reset
//   frame_done : one-cycle pulse when the last pixel of a frame is fetched
module vga_pixel_fetch_ctrl #(
  parameter int               H_DISPLAY       = 640,
  parameter int               V_DISPLAY       = 480,
  parameter int               PIX_W           = 12,
  parameter int               ADDR_W          = 19,
  parameter int               FIFO_DEPTH      = 16,
  parameter logic [PIX_W-1:0] UNDERFLOW_COLOR = 12'hF0F
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [9:0]              hpos,
  input  logic [9:0]              vpos,
  input  logic                    display_on,
  vga_pixel_fetch_ctrl_if.master  mem,
  output logic [PIX_W-1:0]        rgb,
  output logic                    underflow,
  output logic                    frame_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_DISPLAY * V_DISPLAY - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic logic [ADDR_W-1:0] debt_sat_inc(input logic [ADDR_W-1:0] v);
    return (v == {ADDR_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [1:0]        state, state_nxt;
  logic [PIX_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt, fifo_cnt_nxt;
  logic [ADDR_W-1:0] debt, debt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              req_nxt, fd_nxt;
  logic              resync, accept, starve, pop, push, owed, room;
  logic [PIX_W-1:0]  px_p0;

  always_comb begin
    resync = (hpos == 10'd0) && (vpos == 10'(V_DISPLAY));
    accept = mem.mem_req && mem.mem_ack;
    pop    = display_on && (fifo_cnt != '0);
    starve = display_on && (fifo_cnt == '0);
    // A slot starving in this very cycle already owns the word arriving now;
    // pushing it would shift every later pixel by one.
    owed   = (debt != '0) || starve;
    push   = accept && !resync && (state == ST_FETCH) && !owed;
    px_p0  = fifo_mem[rd_ptr];

    debt_nxt = debt;
    if (resync)
      debt_nxt = '0;
    else if (accept && (state == ST_FETCH) && owed)
      debt_nxt = starve ? debt : debt - 1'b1;
    else if (starve)
      debt_nxt = debt_sat_inc(debt);

    fifo_cnt_nxt = resync ? '0 : fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    // Outstanding words plus owed slots must never exceed the FIFO; checking
    // next-cycle values keeps a fresh request from overshooting.
    room = (SUM_W'(fifo_cnt_nxt) + SUM_W'(debt_nxt)) < SUM_W'(FIFO_DEPTH);

    state_nxt = state;
    addr_nxt  = mem.mem_addr;
    req_nxt   = mem.mem_req;
    fd_nxt    = 1'b0;

    if (resync) begin
      if (mem.mem_req && !mem.mem_ack) begin
        state_nxt = ST_DRAIN;
      end else begin
        state_nxt = ST_FETCH;
        addr_nxt  = '0;
        req_nxt   = 1'b1;
      end
    end else begin
      case (state)
        ST_FETCH: begin
          if (accept) begin
            addr_nxt = mem.mem_addr + 1'b1;
            if (mem.mem_addr == LAST_ADDR) begin
              fd_nxt    = 1'b1;
              state_nxt = ST_IDLE;
              req_nxt   = 1'b0;
            end else begin
              req_nxt = room;
            end
          end else if (!mem.mem_req) begin
            req_nxt = room;
          end
        end
        ST_DRAIN: begin
          if (accept) begin
            state_nxt = ST_FETCH;
            addr_nxt  = '0;
            req_nxt   = room;
          end
        end
        default: req_nxt = 1'b0;
      endcase
    end
  end

  // Stage p0 -> output: control, FIFO bookkeeping and registered pixel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      fifo_cnt     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      debt         <= '0;
      rgb          <= '0;
      underflow    <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_nxt;
      mem.mem_req  <= req_nxt;
      mem.mem_addr <= addr_nxt;
      fifo_cnt     <= fifo_cnt_nxt;
      wr_ptr       <= resync ? '0 : wr_ptr + PTR_W'(push);
      rd_ptr       <= resync ? '0 : rd_ptr + PTR_W'(pop);
      debt         <= debt_nxt;
      frame_done   <= fd_nxt;
      underflow    <= underflow | starve;
      if (!display_on)
        rgb <= '0;
      else if (pop)
        rgb <= px_p0;
      else
        rgb <= UNDERFLOW_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= mem.mem_rdata;
  end

  assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && (fifo_cnt == CNT_W'(FIFO_DEPTH))));

endmodule
